// File: rtl/leaf_user_out_fifo_pkg.sv
// Shared definitions for the leaf user-side stream buffers.
package leaf_user_out_fifo_pkg;

  localparam int unsigned LEAF_PAYLOAD_BITS = 32;

  // Selects which register currently feeds the leaf-side data output.
  typedef enum logic {
    SRC_BYPASS = 1'b0,
    SRC_RAM    = 1'b1
  } out_src_e;

  // Occupancy must represent 0..2^depth_bits inclusive.
  function automatic int unsigned occ_width(input int unsigned depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/leaf_fifo_mem.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
module leaf_fifo_mem #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its value while rd_en_i is low.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/leaf_user_out_fifo.sv
// Elastic buffer from a user valid/ready stream to the leaf vld/ack port.
// The head word lives in an output stage (counted in occupancy); further
// words sit in the RAM behind it.
module leaf_user_out_fifo
  import leaf_user_out_fifo_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = LEAF_PAYLOAD_BITS,
  parameter int unsigned DEPTH_BITS      = 4,
  parameter int unsigned ALMOST_FULL_LVL = 12,
  parameter int unsigned CNT_BITS        = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PAYLOAD_BITS-1:0]          din_user,
  input  logic                             din_vld,
  output logic                             din_rdy,
  output logic [PAYLOAD_BITS-1:0]          din_leaf_user2interface,
  output logic                             vld_user2interface,
  input  logic                             ack_interface2user,
  output logic [occ_width(DEPTH_BITS)-1:0] occupancy,
  output logic                             almost_full,
  output logic                             empty,
  output logic [CNT_BITS-1:0]              word_cnt
);

  localparam int unsigned      OCC_W   = occ_width(DEPTH_BITS);
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(2 ** DEPTH_BITS);
  localparam logic [OCC_W-1:0] AF_V    = OCC_W'(ALMOST_FULL_LVL);

  logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    rdy_q, rdy_d;
  logic                    vld_q, vld_d;
  out_src_e                src_q, src_d;
  logic [PAYLOAD_BITS-1:0] byp_q, byp_d;
  logic                    af_q, af_d;
  logic                    empty_q, empty_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;

  logic                    push, pop, slot_free, ram_wr, ram_rd;
  logic [OCC_W-1:0]        ram_cnt;
  logic [PAYLOAD_BITS-1:0] ram_rdata;

  leaf_fifo_mem #(
    .WIDTH     (PAYLOAD_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (ram_wr),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din_user),
    .rd_en_i   (ram_rd),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  // Next-state: route pushes to the output stage or RAM, refill the output stage on pop.
  // The output stage is either the bypass register (word arrived while the RAM
  // was empty) or the RAM read register itself (word fetched from storage);
  // src_q selects which, so both paths reach the leaf in the same edge.
  always_comb begin
    push      = din_vld & rdy_q;
    pop       = vld_q & ack_interface2user;
    ram_cnt   = occ_q - OCC_W'(vld_q);
    slot_free = ~vld_q | pop;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    vld_d     = vld_q;
    src_d     = src_q;
    byp_d     = byp_q;
    if (slot_free) begin
      if (ram_cnt != '0) begin
        ram_rd   = 1'b1;
        rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        vld_d    = 1'b1;
        src_d    = SRC_RAM;
        ram_wr   = push;
      end else if (push) begin
        vld_d = 1'b1;
        src_d = SRC_BYPASS;
        byp_d = din_user;
      end else begin
        vld_d = 1'b0;
      end
    end else begin
      ram_wr = push;
    end
    if (ram_wr) begin
      wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    end
    occ_d   = occ_q + OCC_W'(push) - OCC_W'(pop);
    rdy_d   = (occ_d < DEPTH_V);
    af_d    = (occ_d >= AF_V);
    empty_d = (occ_d == '0);
    cnt_d   = cnt_q + CNT_BITS'(pop);
  end

  // State registers; async reset discards all held words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      src_q    <= SRC_BYPASS;
      byp_q    <= '0;
      af_q     <= 1'b0;
      empty_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
      byp_q    <= byp_d;
      af_q     <= af_d;
      empty_q  <= empty_d;
      cnt_q    <= cnt_d;
    end
  end

  assign din_rdy                 = rdy_q;
  assign vld_user2interface      = vld_q;
  assign din_leaf_user2interface = (src_q == SRC_RAM) ? ram_rdata : byp_q;
  assign occupancy               = occ_q;
  assign almost_full             = af_q;
  assign empty                   = empty_q;
  assign word_cnt                = cnt_q;

endmodule

// File: tb/tb_leaf_user_out_fifo.sv
// Scoreboard bench for leaf_user_out_fifo (DEPTH=16, almost-full at 12).
module tb_leaf_user_out_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_user;
  logic        din_vld;
  logic        din_rdy;
  logic [31:0] dout;
  logic        vld;
  logic        ack;
  logic [4:0]  occupancy;
  logic        almost_full;
  logic        empty;
  logic [31:0] word_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  // Monitor-side reference state: words held and words delivered.
  int          m_occ = 0;
  longint      m_cnt = 0;
  logic        m_rdy = 1'b0;

  leaf_user_out_fifo #(
    .PAYLOAD_BITS    (32),
    .DEPTH_BITS      (4),
    .ALMOST_FULL_LVL (12),
    .CNT_BITS        (32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_user                (din_user),
    .din_vld                 (din_vld),
    .din_rdy                 (din_rdy),
    .din_leaf_user2interface (dout),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .occupancy               (occupancy),
    .almost_full             (almost_full),
    .empty                   (empty),
    .word_cnt                (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state with the reference before each rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", occupancy, longint'(m_occ));
      chk("empty", empty, (m_occ == 0) ? 1 : 0);
      chk("almost_full", almost_full, (m_occ >= AF) ? 1 : 0);
      chk("din_rdy", din_rdy, m_rdy);
      chk("vld", vld, (m_occ > 0) ? 1 : 0);
      chk("word_cnt", word_cnt, m_cnt & 64'hFFFF_FFFF);
      if (m_occ > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: got word %0h expected no word at %0t", dout, $time);
        end else begin
          chk("data", dout, exp_q[0]);
          if (ack) void'(exp_q.pop_front());
        end
        if (ack) begin
          m_occ--;
          m_cnt++;
        end
      end
      if (din_vld && m_rdy) m_occ++;
      m_rdy = (m_occ < DEPTH);
    end else begin
      m_occ = 0;
      m_cnt = 0;
      m_rdy = 1'b0;
    end
  end

  // Drive one cycle of inputs (called at posedge+1) and record accepted words.
  task automatic drive(input logic v, input logic [31:0] d, input logic a, output logic acc);
    din_vld  = v;
    din_user = d;
    ack      = a;
    acc      = v & din_rdy;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   k;
    int   n;
    reset    = 1'b0;
    din_vld  = 1'b0;
    din_user = '0;
    ack      = 1'b0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", din_rdy, 0);
    chk("reset_data", dout, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, acc);
    chk("idle_rdy", din_rdy, 1);
    chk("idle_empty", empty, 1);
    chk("idle_vld", vld, 0);
    chk("idle_cnt", word_cnt, 0);

    // Single word held for ten cycles, then acknowledged.
    drive(1'b1, 32'hDEADBEEF, 1'b0, acc);
    chk("single_vld", vld, 1);
    chk("single_data", dout, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b0, acc);
    drive(1'b0, '0, 1'b1, acc);
    chk("single_vld_after_ack", vld, 0);
    chk("single_cnt", word_cnt, 1);

    // Fill beyond capacity with no acks.
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b0, acc);
    din_vld = 1'b0;
    chk("fill_occ", occupancy, DEPTH);
    chk("fill_rdy", din_rdy, 0);
    chk("fill_af", almost_full, 1);
    chk("fill_accepted", exp_q.size(), DEPTH);
    k = 0;
    while (!empty && k < 40) begin
      drive(1'b0, '0, 1'b1, acc);
      k++;
    end
    chk("drain_cycles", k, DEPTH);
    chk("drain_cnt", word_cnt, 17);
    chk("drain_empty", empty, 1);

    // Streaming: simultaneous push and pop every cycle.
    n = 0;
    k = 0;
    while (n < 1000 && k < 1100) begin
      drive(1'b1, 32'h1000_0000 + 32'(n), 1'b1, acc);
      if (acc) n++;
      k++;
    end
    chk("stream_cycles", k, 1000);
    drive(1'b0, '0, 1'b1, acc);
    chk("stream_cnt", word_cnt, 1017);
    chk("stream_empty", empty, 1);

    // Random push/pop traffic.
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), acc);
    k = 0;
    while (!empty && k < 40) begin
      drive(1'b0, '0, 1'b1, acc);
      k++;
    end
    chk("random_drained", empty, 1);
    chk("random_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-stream with seven words held.
    for (int i = 0; i < 7; i++) drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, acc);
    din_vld = 1'b0;
    chk("pre_reset_occ", occupancy, 7);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("async_occ", occupancy, 0);
    chk("async_vld", vld, 0);
    chk("async_data", dout, 0);
    chk("async_rdy", din_rdy, 0);
    chk("async_empty", empty, 1);
    chk("async_af", almost_full, 0);
    chk("async_cnt", word_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    reset  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'($urandom_range(0, 1)), acc);
    chk("post_reset_vld", vld, 0);
    drive(1'b1, 32'hCAFE0001, 1'b0, acc);
    chk("post_reset_data", dout, 32'hCAFE0001);
    drive(1'b0, '0, 1'b1, acc);
    drive(1'b0, '0, 1'b0, acc);
    chk("post_reset_cnt", word_cnt, 1);
    chk("post_reset_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
